// File: rtl/nn_pkg.sv
// Shared types for the layer output path: FSM encoding and an address-width helper.
package nn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } nn_state_t;

  // ceil(log2(n)), never below 1 so a single-entry bank still has an address bit
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/output_round_sat.sv
// Combinational post-processing of one accumulator: round half up, drop FRAC_BITS,
// saturate to DATA_W signed, optional ReLU. Zero latency, no flow control.
module output_round_sat #(
  parameter int ACC_W     = 32,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int RELU_EN   = 0
) (
  input  logic signed [ACC_W-1:0]  acc_value,
  output logic signed [DATA_W-1:0] result
);

  localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] OUT_MIN = ~OUT_MAX;

  logic signed [ACC_W:0] half;
  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] shifted;

  generate
    if (FRAC_BITS > 0) begin : g_round
      assign half = (ACC_W+1)'(1) << (FRAC_BITS - 1);
    end else begin : g_no_round
      assign half = '0;
    end
  endgenerate

  // one guard bit so the rounding add cannot wrap at the positive limit
  assign sum     = $signed({acc_value[ACC_W-1], acc_value}) + half;
  assign shifted = sum >>> FRAC_BITS;

  always_comb begin
    result = shifted[DATA_W-1:0];
    if (shifted > OUT_MAX) begin
      result = OUT_MAX[DATA_W-1:0];
    end else if (shifted < OUT_MIN) begin
      result = OUT_MIN[DATA_W-1:0];
    end
    if ((RELU_EN != 0) && result[DATA_W-1]) begin
      result = '0;
    end
  end

endmodule

// File: rtl/output_accumulator_bank.sv
// Round-robin saturating accumulator bank; drains post-processed words to the output RAM.
// First write request one cycle after last_element; writes hold stable while output_ram_ready is low.
module output_accumulator_bank
  import nn_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ACC_W       = 32,
  parameter int NUM_OUTPUTS = 8,
  parameter int FRAC_BITS   = 8,
  parameter int RELU_EN     = 0,
  localparam int ADDR_W     = clog2_min1(NUM_OUTPUTS)
) (
  input  logic                     clock,
  input  logic                     clear_n,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] active_z,
  input  logic signed [DATA_W-1:0] active_m,
  input  logic                     next_element,
  input  logic                     last_element,
  input  logic                     output_ram_ready,
  output logic [ADDR_W-1:0]        output_ram_address,
  output logic [DATA_W-1:0]        output_ram_data,
  output logic                     output_ram_enable,
  output logic                     output_ram_write,
  output logic                     acc_overflow,
  output logic                     finished
);

  localparam logic [ADDR_W-1:0]      LAST_IDX = ADDR_W'(NUM_OUTPUTS - 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  nn_state_t                  state_q, state_d;
  logic signed [ACC_W-1:0]    acc_q [NUM_OUTPUTS];
  logic [ADDR_W-1:0]          sel_q, idx_q, sel_nxt, idx_nxt, rd_idx;
  logic                       ovf_q, en_q, fin_q;
  logic signed [DATA_W-1:0]   data_q, post_val;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W:0]      sum;
  logic signed [ACC_W-1:0]    acc_sel, acc_new, round_in;
  logic                       sat_hit, do_acc, accept;

  assign prod    = active_z * active_m;
  assign acc_sel = acc_q[sel_q];
  assign sum     = $signed({acc_sel[ACC_W-1], acc_sel})
                 + $signed({{(ACC_W+1-2*DATA_W){prod[2*DATA_W-1]}}, prod});
  assign sat_hit = sum[ACC_W] ^ sum[ACC_W-1];
  assign acc_new = sat_hit ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];

  assign do_acc  = (state_q == ST_ACCUM) && next_element;
  assign accept  = en_q && output_ram_ready;
  assign sel_nxt = (sel_q == LAST_IDX) ? '0 : sel_q + 1'b1;
  assign idx_nxt = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

  // Data is registered one word ahead: slot 0 on entry to DRAIN (bypassing a
  // same-cycle update of slot 0), otherwise the word after the one being accepted.
  assign rd_idx   = (state_q == ST_DRAIN) ? idx_nxt : '0;
  assign round_in = (do_acc && (sel_q == '0)) ? acc_new : acc_q[rd_idx];

  output_round_sat #(
    .ACC_W     (ACC_W),
    .DATA_W    (DATA_W),
    .FRAC_BITS (FRAC_BITS),
    .RELU_EN   (RELU_EN)
  ) u_post (
    .acc_value (round_in),
    .result    (post_val)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: if (last_element) state_d = ST_DRAIN;
      ST_DRAIN: if (accept && (idx_q == LAST_IDX)) state_d = ST_DONE;
      default:  state_d = state_q;
    endcase
    if (start) state_d = ST_ACCUM;
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= ST_IDLE;
      for (int k = 0; k < NUM_OUTPUTS; k++) acc_q[k] <= '0;
      sel_q  <= '0;
      idx_q  <= '0;
      ovf_q  <= 1'b0;
      en_q   <= 1'b0;
      fin_q  <= 1'b0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        for (int k = 0; k < NUM_OUTPUTS; k++) acc_q[k] <= '0;
        sel_q  <= '0;
        idx_q  <= '0;
        ovf_q  <= 1'b0;
        en_q   <= 1'b0;
        fin_q  <= 1'b0;
        data_q <= '0;
      end else if (state_q == ST_ACCUM) begin
        if (next_element) begin
          acc_q[sel_q] <= acc_new;
          sel_q        <= sel_nxt;
          ovf_q        <= ovf_q | sat_hit;
        end
        if (last_element) begin
          en_q   <= 1'b1;
          idx_q  <= '0;
          data_q <= post_val;
        end
      end else if ((state_q == ST_DRAIN) && accept) begin
        if (idx_q == LAST_IDX) begin
          en_q  <= 1'b0;
          fin_q <= 1'b1;
        end else begin
          idx_q  <= idx_nxt;
          data_q <= post_val;
        end
      end
    end
  end

  assign output_ram_address = idx_q;
  assign output_ram_data    = data_q;
  assign output_ram_enable  = en_q;
  assign output_ram_write   = en_q;
  assign acc_overflow       = ovf_q;
  assign finished           = fin_q;

endmodule

// File: tb/tb_output_accumulator_bank.sv
// Three bank configurations driven in lockstep and checked against a plain-arithmetic model.
module tb_output_accumulator_bank;

  logic        clock = 1'b0;
  logic        clear_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] active_z = '0;
  logic [15:0] active_m = '0;
  logic        next_element = 1'b0;
  logic        last_element = 1'b0;
  logic        output_ram_ready = 1'b1;

  logic [2:0]  addr0, addr1;
  logic [0:0]  addr2;
  logic [15:0] data0, data1, data2;
  logic        en0, en1, en2, wr0, wr1, wr2, ovf0, ovf1, ovf2, fin0, fin1, fin2;

  always #5 clock = ~clock;

  output_accumulator_bank u_dut0 (
    .clock(clock), .clear_n(clear_n), .start(start), .active_z(active_z), .active_m(active_m),
    .next_element(next_element), .last_element(last_element), .output_ram_ready(output_ram_ready),
    .output_ram_address(addr0), .output_ram_data(data0), .output_ram_enable(en0),
    .output_ram_write(wr0), .acc_overflow(ovf0), .finished(fin0));

  output_accumulator_bank #(.RELU_EN(1)) u_dut1 (
    .clock(clock), .clear_n(clear_n), .start(start), .active_z(active_z), .active_m(active_m),
    .next_element(next_element), .last_element(last_element), .output_ram_ready(output_ram_ready),
    .output_ram_address(addr1), .output_ram_data(data1), .output_ram_enable(en1),
    .output_ram_write(wr1), .acc_overflow(ovf1), .finished(fin1));

  output_accumulator_bank #(.NUM_OUTPUTS(1), .FRAC_BITS(0)) u_dut2 (
    .clock(clock), .clear_n(clear_n), .start(start), .active_z(active_z), .active_m(active_m),
    .next_element(next_element), .last_element(last_element), .output_ram_ready(output_ram_ready),
    .output_ram_address(addr2), .output_ram_data(data2), .output_ram_enable(en2),
    .output_ram_write(wr2), .acc_overflow(ovf2), .finished(fin2));

  logic [3:0]  obs_addr [3];
  logic [15:0] obs_data [3];
  logic        obs_en [3], obs_wr [3], obs_ovf [3], obs_fin [3];
  assign obs_addr[0] = {1'b0, addr0};
  assign obs_addr[1] = {1'b0, addr1};
  assign obs_addr[2] = {3'b000, addr2};
  assign obs_data[0] = data0;  assign obs_data[1] = data1;  assign obs_data[2] = data2;
  assign obs_en[0]   = en0;    assign obs_en[1]   = en1;    assign obs_en[2]   = en2;
  assign obs_wr[0]   = wr0;    assign obs_wr[1]   = wr1;    assign obs_wr[2]   = wr2;
  assign obs_ovf[0]  = ovf0;   assign obs_ovf[1]  = ovf1;   assign obs_ovf[2]  = ovf2;
  assign obs_fin[0]  = fin0;   assign obs_fin[1]  = fin1;   assign obs_fin[2]  = fin2;

  // Reference model: per configuration, outputs count, fraction bits, ReLU flag.
  int     ncfg [3] = '{8, 8, 1};
  int     fcfg [3] = '{8, 8, 0};
  int     rcfg [3] = '{0, 1, 0};
  longint macc [3][8];
  int     msel [3];
  bit     movf [3];
  int     checks = 0;
  int     errors = 0;

  localparam longint AMAX = 64'sd2147483647;
  localparam longint AMIN = -64'sd2147483648;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] post_model(input longint x, input int f, input int relu);
    longint r;
    r = (f > 0) ? ((x + (64'sd1 <<< (f - 1))) >>> f) : x;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    if (relu != 0 && r < 0) r = 0;
    return 16'(r);
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 3; c++) begin
      for (int s = 0; s < 8; s++) macc[c][s] = 0;
      msel[c] = 0;
      movf[c] = 1'b0;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    model_clear();
  endtask

  task automatic elem(input logic [15:0] z, input logic [15:0] m, input bit nx, input bit ls);
    longint p, s;
    active_z = z; active_m = m; next_element = nx; last_element = ls;
    @(negedge clock);
    next_element = 1'b0; last_element = 1'b0;
    if (nx) begin
      p = longint'($signed(z)) * longint'($signed(m));
      for (int c = 0; c < 3; c++) begin
        s = macc[c][msel[c]] + p;
        if (s > AMAX) begin s = AMAX; movf[c] = 1'b1; end
        if (s < AMIN) begin s = AMIN; movf[c] = 1'b1; end
        macc[c][msel[c]] = s;
        msel[c] = (msel[c] + 1) % ncfg[c];
      end
    end
  endtask

  // Called at the first DRAIN negedge; walks every bank's write sequence.
  task automatic drain_all(input int stall_addr, input int stall_len, input bit rand_rdy);
    int j [3];
    bit dn [3];
    int stalls, held;
    stalls = stall_len;
    held = 0;
    for (int c = 0; c < 3; c++) begin j[c] = 0; dn[c] = 1'b0; end
    for (int k = 0; k < 200 && !(dn[0] && dn[1] && dn[2]); k++) begin
      for (int c = 0; c < 3; c++) begin
        if (!dn[c]) begin
          if (j[c] < ncfg[c]) begin
            chk($sformatf("d%0d_en", c), obs_en[c], 1);
            chk($sformatf("d%0d_wr", c), obs_wr[c], 1);
            chk($sformatf("d%0d_addr", c), obs_addr[c], j[c]);
            chk($sformatf("d%0d_data%0d", c, j[c]), obs_data[c],
                post_model(macc[c][j[c]], fcfg[c], rcfg[c]));
          end else begin
            chk($sformatf("d%0d_en_done", c), obs_en[c], 0);
            chk($sformatf("d%0d_finished", c), obs_fin[c], 1);
            chk($sformatf("d%0d_ovf", c), obs_ovf[c], movf[c]);
            if (c == 0) chk("d0_drain_cycles", k, ncfg[0] + held);
            dn[c] = 1'b1;
          end
        end
      end
      if (stalls > 0 && !dn[0] && j[0] == stall_addr) begin
        output_ram_ready = 1'b0;
        stalls--;
      end else if (rand_rdy) begin
        output_ram_ready = ($urandom_range(0, 2) != 0);
      end else begin
        output_ram_ready = 1'b1;
      end
      if (!output_ram_ready && !dn[0]) held++;
      for (int c = 0; c < 3; c++)
        if (!dn[c] && j[c] < ncfg[c] && output_ram_ready) j[c]++;
      @(negedge clock);
    end
    if (!(dn[0] && dn[1] && dn[2])) chk("drain_timeout", 0, 1);
    output_ram_ready = 1'b1;
  endtask

  task automatic layer_uniform(input logic [15:0] z, input logic [15:0] m);
    do_start();
    for (int e = 0; e < 8; e++) elem(z, m, 1'b1, e == 7);
    drain_all(-1, 0, 1'b0);
  endtask

  initial begin
    int cnt;
    model_clear();
    #2;
    chk("rst_en", en0, 0);
    chk("rst_fin", fin0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_addr", addr0, 0);
    chk("rst_data", data0, 0);
    @(negedge clock);
    clear_n = 1'b1;
    @(negedge clock);

    // 1: uniform products, ready held high
    layer_uniform(16'h0100, 16'h0200);

    // 2: saturation in the single-slot bank
    do_start();
    for (int e = 0; e < 3; e++) elem(16'h7FFF, 16'h7FFF, 1'b1, e == 2);
    chk("d2_acc_model_sat", macc[2][0], AMAX);
    drain_all(-1, 0, 1'b0);

    // 3: backpressure while address 2 is presented
    do_start();
    for (int e = 0; e < 8; e++) elem(16'($urandom), 16'($urandom), 1'b1, e == 7);
    drain_all(2, 3, 1'b0);

    // 4: negative result with and without ReLU, last_element on its own cycle
    do_start();
    elem(16'hFF00, 16'h0100, 1'b1, 1'b0);
    elem(16'h0000, 16'h0000, 1'b0, 1'b1);
    drain_all(-1, 0, 1'b0);

    // randomized layers with random ready
    for (int l = 0; l < 4; l++) begin
      do_start();
      cnt = $urandom_range(1, 40);
      for (int e = 0; e < cnt; e++)
        elem(16'($urandom), 16'($urandom), ($urandom_range(0, 4) != 0), e == cnt - 1);
      drain_all(-1, 0, 1'b1);
    end

    // 5: restart mid-drain at address 4
    do_start();
    for (int e = 0; e < 8; e++) elem(16'($urandom), 16'($urandom), 1'b1, e == 7);
    cnt = 0;
    while (addr0 != 3'd4 && cnt < 20) begin @(negedge clock); cnt++; end
    chk("abort_reached_addr4", addr0, 4);
    do_start();
    chk("abort_en", en0, 0);
    chk("abort_fin", fin0, 0);
    chk("abort_ovf", ovf0, 0);
    for (int e = 0; e < 8; e++) elem(16'h0100, 16'h0100, 1'b1, e == 7);
    drain_all(-1, 0, 1'b0);

    // 6: asynchronous reset mid-accumulate, then a normal layer
    do_start();
    for (int e = 0; e < 3; e++) elem(16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
    chk("pre_reset_ovf2", ovf2, 1);
    #2 clear_n = 1'b0;
    #1;
    chk("areset_ovf2", ovf2, 0);
    chk("areset_en", en0, 0);
    chk("areset_fin", fin0, 0);
    chk("areset_addr", addr0, 0);
    chk("areset_data", data0, 0);
    model_clear();
    @(negedge clock);
    clear_n = 1'b1;
    @(negedge clock);
    layer_uniform(16'h0100, 16'h0200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
